// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding
// (mirrored on state_code) and the "no operation" selector value.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    localparam logic [2:0] SEL_NOTUSE = 3'b000;

endpackage

// File: rtl/alu_operand_sequencer_debounce.sv
// button_debounce: 2-flop synchroniser, stability counter and armed flag;
// emits a one-cycle press pulse on an accepted, armed 0->1 transition.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          armed_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    logic changing;
    logic arming;
    logic counting;
    logic done;

    // A released level must also survive the full window before arming,
    // so a button held across reset never produces a press.
    assign changing = sync2_q != level_q;
    assign arming   = !armed_q && !sync2_q && !level_q;
    assign counting = changing || arming;
    assign done     = counting && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (!counting) begin
                cnt_q <= '0;
            end else if (done) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                armed_q <= armed_q | ~sync2_q;
                press_q <= sync2_q & armed_q & changing;
            end else if (sync1_q != sync2_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Switch/button front end for the combinational 8-bit ALU: A -> B -> op entry,
// settle, capture. CHAIN_RESULT_EN: enter in HOLD feeds res_s back into op_a.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       cin_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [7:0] alu_s,
    input  logic       alu_cout,
    input  logic       alu_zero,
    input  logic       alu_error,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_cin,
    output logic [2:0] op_sel,
    output logic [7:0] res_s,
    output logic       res_cout,
    output logic       res_zero,
    output logic       res_error,
    output logic       res_valid,
    output logic       sel_reject,
    output logic [2:0] state_code
);

    localparam int unsigned SCW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    logic enter_press;
    logic clear_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_enter),
        .press_o(enter_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clear),
        .press_o(clear_press)
    );

    state_e         state_q;
    logic [7:0]     op_a_q;
    logic [7:0]     op_b_q;
    logic           op_cin_q;
    logic [2:0]     op_sel_q;
    logic [7:0]     res_s_q;
    logic           res_cout_q;
    logic           res_zero_q;
    logic           res_error_q;
    logic           res_valid_q;
    logic           sel_reject_q;
    logic [SCW-1:0] settle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            op_sel_q     <= SEL_NOTUSE;
            res_s_q      <= '0;
            res_cout_q   <= 1'b0;
            res_zero_q   <= 1'b0;
            res_error_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            sel_reject_q <= 1'b0;
            settle_q     <= '0;
        end else begin
            res_valid_q  <= 1'b0;
            sel_reject_q <= 1'b0;
            if (clear_press) begin
                state_q     <= ST_LOAD_A;
                op_a_q      <= '0;
                op_b_q      <= '0;
                op_cin_q    <= 1'b0;
                op_sel_q    <= SEL_NOTUSE;
                res_s_q     <= '0;
                res_cout_q  <= 1'b0;
                res_zero_q  <= 1'b0;
                res_error_q <= 1'b0;
                settle_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_LOAD_A: if (enter_press) begin
                        op_a_q  <= sw;
                        state_q <= ST_LOAD_B;
                    end
                    ST_LOAD_B: if (enter_press) begin
                        op_b_q  <= sw;
                        state_q <= ST_LOAD_OP;
                    end
                    ST_LOAD_OP: if (enter_press) begin
                        if (sw[2:0] != SEL_NOTUSE) begin
                            op_sel_q <= sw[2:0];
                            op_cin_q <= cin_sw;
                            settle_q <= '0;
                            state_q  <= ST_EXEC;
                        end else begin
                            sel_reject_q <= 1'b1;
                        end
                    end
                    ST_EXEC: begin
                        if (settle_q == SETTLE_LAST) begin
                            res_s_q     <= alu_s;
                            res_cout_q  <= alu_cout;
                            res_zero_q  <= alu_zero;
                            res_error_q <= alu_error;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            settle_q <= settle_q + SCW'(1);
                        end
                    end
                    ST_HOLD: if (enter_press) begin
                        op_sel_q <= SEL_NOTUSE;
`ifdef CHAIN_RESULT_EN
                        op_a_q   <= res_s_q;
                        state_q  <= ST_LOAD_B;
`else
                        state_q  <= ST_LOAD_A;
`endif
                    end
                    default: state_q <= ST_LOAD_A;
                endcase
            end
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_cin     = op_cin_q;
    assign op_sel     = op_sel_q;
    assign res_s      = res_s_q;
    assign res_cout   = res_cout_q;
    assign res_zero   = res_zero_q;
    assign res_error  = res_error_q;
    assign res_valid  = res_valid_q;
    assign sel_reject = sel_reject_q;
    assign state_code = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed, table-driven bench for alu_operand_sequencer with a small
// combinational ALU model in the loop (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2).
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       cin_sw = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] alu_s;
    logic       alu_cout, alu_zero, alu_error;
    logic [7:0] op_a, op_b, res_s;
    logic       op_cin, res_cout, res_zero, res_error;
    logic       res_valid, sel_reject;
    logic [2:0] op_sel, state_code;

    int n_pass = 0;
    int n_tot  = 0;
    int rv_cnt = 0;
    int rej_cnt = 0;
    int cyc = 0;
    int exec_cyc = 0;
    int lat = -1;
    logic [2:0] prev_state = '0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .cin_sw    (cin_sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .alu_s     (alu_s),
        .alu_cout  (alu_cout),
        .alu_zero  (alu_zero),
        .alu_error (alu_error),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .op_sel    (op_sel),
        .res_s     (res_s),
        .res_cout  (res_cout),
        .res_zero  (res_zero),
        .res_error (res_error),
        .res_valid (res_valid),
        .sel_reject(sel_reject),
        .state_code(state_code)
    );

    // ALU model: 1 add, 2 sub, 3 and, 4 or, 5 xor, anything else errors
    always_comb begin
        logic [8:0] t;
        t = '0;
        alu_error = 1'b0;
        case (op_sel)
            3'd1: t = {1'b0, op_a} + {1'b0, op_b} + {8'd0, op_cin};
            3'd2: t = {1'b0, op_a} + {1'b0, ~op_b} + 9'd1;
            3'd3: t = {1'b0, op_a & op_b};
            3'd4: t = {1'b0, op_a | op_b};
            3'd5: t = {1'b0, op_a ^ op_b};
            default: alu_error = 1'b1;
        endcase
        alu_s    = t[7:0];
        alu_cout = t[8];
        alu_zero = (t[7:0] == 8'd0);
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (res_valid) begin
            rv_cnt <= rv_cnt + 1;
            lat    <= cyc - exec_cyc;
        end
        if (sel_reject) rej_cnt <= rej_cnt + 1;
        if (state_code == 3'd3 && prev_state != 3'd3) exec_cyc <= cyc;
        prev_state <= state_code;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic ent, input logic clr);
        btn_enter = ent;
        btn_clear = clr;
        wait_cycles(10);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        wait_cycles(10);
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        sw = a;
        press(1'b1, 1'b0);
        sw = b;
        press(1'b1, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int rv0, rej0;
        bit seen;
        vecs[0] = '{8'd25,  8'd17,  3'd1, 1'b0, 8'd42,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 3'd1, 1'b1, 8'd45,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'd5,   8'd5,   3'd2, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hF0,  8'h3C,  3'd3, 1'b0, 8'h30,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h12,  8'h21,  3'd4, 1'b1, 8'h33,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h0F,  8'hF0,  3'd5, 1'b0, 8'hFF,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'd1,   8'd2,   3'd7, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1};

        wait_cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset state", state_code, 3'd0);
        check("reset op_a/b", {op_a, op_b}, 16'd0);
        check("reset res", {res_s, res_cout, res_zero, res_error}, 11'd0);
        check("reset pulses", {res_valid, sel_reject, op_sel, op_cin}, 6'd0);
        wait_cycles(10);

        for (int i = 0; i < 7; i++) begin
            press(1'b0, 1'b1);
            load_ab(vecs[i].a, vecs[i].b);
            sw = {5'd0, vecs[i].sel};
            cin_sw = vecs[i].cin;
            rv0 = rv_cnt;
            press(1'b1, 1'b0);
            check($sformatf("v%0d res_s", i), res_s, vecs[i].s);
            check($sformatf("v%0d cout", i), res_cout, vecs[i].cout);
            check($sformatf("v%0d zero", i), res_zero, vecs[i].zero);
            check($sformatf("v%0d error", i), res_error, vecs[i].err);
            check($sformatf("v%0d state", i), state_code, 3'd4);
            check($sformatf("v%0d op_sel", i), op_sel, vecs[i].sel);
            check($sformatf("v%0d valid pulses", i), rv_cnt - rv0, 1);
            check($sformatf("v%0d latency", i), lat, 2);
        end

        // bounce: three one-cycle toggles then a steady hold
        press(1'b0, 1'b1);
        sw = 8'h5A;
        btn_enter = 1'b1; @(negedge clk);
        btn_enter = 1'b0; @(negedge clk);
        btn_enter = 1'b1; @(negedge clk);
        press(1'b1, 1'b0);
        check("bounce state", state_code, 3'd1);
        check("bounce op_a", op_a, 8'h5A);

        // selector 000 is rejected in LOAD_OP
        sw = 8'h33;
        press(1'b1, 1'b0);
        sw = 8'hF8;
        rej0 = rej_cnt;
        press(1'b1, 1'b0);
        check("reject pulses", rej_cnt - rej0, 1);
        check("reject state", state_code, 3'd2);
        check("reject op_sel", op_sel, 3'd0);

        // clear and enter accepted together: clear wins
        press(1'b0, 1'b1);
        sw = 8'hAA;
        press(1'b1, 1'b0);
        check("prio pre op_a", op_a, 8'hAA);
        sw = 8'h11;
        press(1'b1, 1'b1);
        check("prio op_a", op_a, 8'd0);
        check("prio state", state_code, 3'd0);

        // reset while in EXEC, enter held straight through it
        load_ab(8'd9, 8'd8);
        sw = 8'd1;
        rv0 = rv_cnt;
        btn_enter = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (state_code == 3'd3) seen = 1'b1;
        end
        check("reach EXEC", seen, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst state", state_code, 3'd0);
        check("rst ops", {op_a, op_b, op_sel, op_cin}, 20'd0);
        check("rst res", {res_s, res_cout, res_zero, res_error, res_valid}, 12'd0);
        wait_cycles(15);
        check("rst held no press", state_code, 3'd0);
        btn_enter = 1'b0;
        wait_cycles(15);
        check("rst no capture", rv_cnt - rv0, 0);
        check("rst op_a", op_a, 8'd0);

        // HOLD -> enter: chaining vs plain return
        load_ab(8'd25, 8'd17);
        sw = 8'd1;
        cin_sw = 1'b0;
        press(1'b1, 1'b0);
        check("chain pre res_s", res_s, 8'd42);
        sw = 8'd0;
        press(1'b1, 1'b0);
`ifdef CHAIN_RESULT_EN
        check("chain op_a", op_a, 8'd42);
        check("chain state", state_code, 3'd1);
`else
        check("nochain op_a", op_a, 8'd25);
        check("nochain state", state_code, 3'd0);
`endif
        check("hold exit op_sel", op_sel, 3'd0);
        check("hold exit res_s", res_s, 8'd42);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
